trig_delay_gen: RTL

TRIG_DELAY_GEN -- requirements
Module: trig_delay_gen

---
 rtl/trig_gen_pkg.sv | 26 ++
 rtl/trig_delay_ch.sv | 93 +++++++++
 rtl/trig_delay_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/trig_gen_pkg.sv
// Shared definitions for the trigger delay generator: source-select codes,
// per-channel FSM encoding and the saturating drop-counter helper.
package trig_gen_pkg;

  localparam logic [1:0] MODE_EXT = 2'd0;
  localparam logic [1:0] MODE_INT = 2'd1;
  localparam logic [1:0] MODE_CH0 = 2'd2;
  localparam logic [1:0] MODE_OR  = 2'd3;

  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } ch_state_e;

  // Up to 16 channels can reject in one cycle, hence a 5-bit increment.
  function automatic logic [DROP_W-1:0] sat_add16(input logic [DROP_W-1:0] a,
                                                  input logic [4:0]        b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {{(DROP_W-4){1'b0}}, b};
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/trig_delay_ch.sv
// One L1 channel: rising-edge detect, delay/width sequencing and a per-cycle
// reject flag for edges that cannot be serviced.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for an accepted rising edge
// ST_DELAY | counting the latched delay down; busy aborts to ST_IDLE
// ST_PULSE | pulse output high while the latched width counts down
module trig_delay_ch
  import trig_gen_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             l1,
  input  logic             en,
  input  logic             busy,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic             pulse,
  output logic             reject
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_e        state, state_nxt;
  logic             l1_q;
  logic             rise;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] wid_lat, wid_nxt;

  assign rise = l1 & ~l1_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wid_nxt   = wid_lat;
    reject    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          if (en && !busy) begin
            state_nxt = ST_DELAY;
            cnt_nxt   = delay;
            // Width 0 is treated as a single-cycle pulse.
            wid_nxt   = (width == '0) ? '0 : width - ONE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        reject = rise;
        if (busy) begin
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = wid_lat;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      ST_PULSE: begin
        reject = rise;
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pulse is a dedicated flop so the output never sees state-decode glitches.
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= ST_IDLE;
      l1_q    <= 1'b0;
      cnt     <= '0;
      wid_lat <= '0;
      pulse   <= 1'b0;
    end else begin
      state   <= state_nxt;
      l1_q    <= l1;
      cnt     <= cnt_nxt;
      wid_lat <= wid_nxt;
      pulse   <= (state_nxt == ST_PULSE);
    end
  end

endmodule

// File: rtl/trig_delay_gen.sv
// Trigger delay generator: NCH delayed L1 channels, internal periodic trigger,
// source-selected registered trigger and reject counter. Define
// TRIG_DELAY_GEN_PPS_EN to build the pulse-per-second divider.
module trig_delay_gen
  import trig_gen_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CNT_W      = 14,
  parameter int INT_PERIOD = 10000,
  parameter int PPS_DIV    = 5000000
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NCH-1:0]     l1_in,
  input  logic               ext_trg,
  input  logic               busy,
  input  logic [1:0]         mode,
  input  logic [NCH-1:0]     ch_en,
  input  logic [NCH*CNT_W-1:0] delay,
  input  logic [NCH*CNT_W-1:0] width,
  output logic               trg_out,
  output logic [NCH-1:0]     ch_pulse,
  output logic               int_trg,
  output logic [15:0]        drop_cnt,
  output logic               pps
);

  localparam int INT_W = $clog2(INT_PERIOD);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(INT_PERIOD - 1);

  logic [NCH-1:0]   reject;
  logic [4:0]       rej_sum;
  logic [INT_W-1:0] int_cnt;
  logic             src;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    trig_delay_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (clk),
      .RST    (RST),
      .l1     (l1_in[gi]),
      .en     (ch_en[gi]),
      .busy   (busy),
      .delay  (delay[gi*CNT_W +: CNT_W]),
      .width  (width[gi*CNT_W +: CNT_W]),
      .pulse  (ch_pulse[gi]),
      .reject (reject[gi])
    );
  end

  always_comb begin
    rej_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      rej_sum = rej_sum + 5'(reject[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= sat_add16(drop_cnt, rej_sum);
    end
  end

  // Period counter runs from 0 so the first int_trg lands at INT_PERIOD-1.
  always_ff @(posedge clk) begin
    if (RST) begin
      int_cnt <= '0;
      int_trg <= 1'b0;
    end else begin
      int_trg <= (int_cnt == INT_LAST);
      int_cnt <= (int_cnt == INT_LAST) ? '0 : int_cnt + INT_W'(1);
    end
  end

  always_comb begin
    src = 1'b0;
    case (mode)
      MODE_EXT: src = ext_trg;
      MODE_INT: src = int_trg;
      MODE_CH0: src = ch_pulse[0];
      MODE_OR:  src = |ch_pulse;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      trg_out <= 1'b0;
    end else begin
      trg_out <= src;
    end
  end

`ifdef TRIG_DELAY_GEN_PPS_EN
  localparam int PPS_W = (PPS_DIV > 1) ? $clog2(PPS_DIV) : 1;
  localparam logic [PPS_W-1:0] PPS_LAST = PPS_W'(PPS_DIV - 1);

  logic [PPS_W-1:0] pps_cnt;
  logic             pps_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      pps_cnt <= '0;
      pps_q   <= 1'b0;
    end else if (pps_cnt == PPS_LAST) begin
      pps_cnt <= '0;
      pps_q   <= ~pps_q;
    end else begin
      pps_cnt <= pps_cnt + PPS_W'(1);
    end
  end

  assign pps = pps_q;
`else
  // PPS_DIV stays referenced so builds without the divider keep the same
  // parameter list; the output is tied low.
  localparam logic PPS_DIV_VALID = (PPS_DIV > 0);
  assign pps = PPS_DIV_VALID & 1'b0;
`endif

endmodule
